// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Holds the FSM state encoding and the step-counter sizing rule.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-step adder still needs a 1-bit counter to keep the code uniform.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The slave side is the adder; the master side is the producer/consumer.
interface serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );

endinterface

// File: rtl/serial_adder_adder_slice.sv
// Combinational DIGIT-bit ripple adder used once per step by serial_adder.
// Also exposes the carry entering the top bit so the caller can form overflow.
module adder_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic c;

  always_comb begin
    s        = '0;
    c_msb_in = 1'b0;
    c        = ci;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB slice first,
// with a valid/ready handshake on both the operand and the result side.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_width_check
    $error("serial_adder: WIDTH must be a positive integer multiple of DIGIT");
  end

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    k_q;
  logic             carry_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT-1:0] x_sl;
  logic [DIGIT-1:0] y_sl;
  logic [DIGIT-1:0] s_sl;
  logic             co_sl;
  logic             cmsb_sl;
  logic             last_step;

  assign last_step = (k_q == LAST);

  // Slice selection uses constant part-selects so no variable index reaches the datapath.
  always_comb begin
    x_sl = '0;
    y_sl = '0;
    for (int j = 0; j < STEPS; j++) begin
      if (k_q == CW'(j)) begin
        x_sl = opa_q[j*DIGIT +: DIGIT];
        y_sl = opb_q[j*DIGIT +: DIGIT];
      end
    end
  end

  adder_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .x        (x_sl),
    .y        (y_sl),
    .ci       (carry_q),
    .s        (s_sl),
    .co       (co_sl),
    .c_msb_in (cmsb_sl)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_step)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Subtraction is A + ~B + ~borrow, so the inversion happens once at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q     <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            opa_q   <= bus.a;
            opb_q   <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.cin ^ bus.sub;
            k_q     <= '0;
          end
        end
        RUN: begin
          for (int j = 0; j < STEPS; j++) begin
            if (k_q == CW'(j)) sum_q[j*DIGIT +: DIGIT] <= s_sl;
          end
          carry_q <= co_sl;
          if (last_step) begin
            k_q    <= '0;
            cout_q <= co_sl;
            ovf_q  <= cmsb_sl ^ co_sl;
          end else begin
            k_q <= k_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a 16-bit/4-bit-digit instance and a 1-bit instance,
// checked against constant vectors, hand sequences and an arithmetic model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(16)) bus16 ();
  serial_adder_if #(.WIDTH(1))  bus1 ();

  serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  serial_adder #(.WIDTH(1), .DIGIT(1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Reference: true integer arithmetic; overflow when the signed result leaves the 16-bit range.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
    int          sa, sb, r;
    logic [16:0] full;
    logic        co, ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      full = {1'b0, a} + {1'b0, b} + 17'(cin);
      co   = full[16];
      r    = sa + sb + int'(cin);
    end else begin
      full = {1'b0, a} - {1'b0, b} - 17'(cin);
      co   = ~full[16];
      r    = sa - sb - int'(cin);
    end
    ov = (r > 32767) || (r < -32768);
    return {ov, co, full[15:0]};
  endfunction

  task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    bus16.a        = a;
    bus16.b        = b;
    bus16.cin      = cin;
    bus16.sub      = sub;
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
  endtask

  task automatic wait16(output int lat);
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume16;
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          d;
    logic [15:0] ra, rb, held;
    logic        rc, rs;
    logic [17:0] exp18;
    logic [2:0]  vv;
    logic        seen;

    rst_n = 1'b0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
    bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;

    tbl[0] = '{16'h1234, 16'h0FF0, 1'b0, 1'b0, 16'h2224, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
    tbl[7] = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus16.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus16.out_valid), 32'd0);
    check("rst_sum",       32'(bus16.sum),       32'd0);
    check("rst_c_out",     32'(bus16.c_out),     32'd0);
    check("rst_ovf",       32'(bus16.ovf),       32'd0);
    check("rst1_in_ready", 32'(bus1.in_ready),   32'd1);
    rst_n = 1'b1;

    // Constant vectors; the first is offered on the first edge after release
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tbl%0d_rdy", i), 32'(bus16.in_ready), 32'd1);
      start16(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      wait16(lat);
      check($sformatf("tbl%0d_lat", i), 32'(lat), 32'd4);
      check($sformatf("tbl%0d_sum", i), 32'(bus16.sum), 32'(tbl[i].s));
      check($sformatf("tbl%0d_cout", i), 32'(bus16.c_out), 32'(tbl[i].co));
      check($sformatf("tbl%0d_ovf", i), 32'(bus16.ovf), 32'(tbl[i].ov));
      consume16();
    end

    // 1-bit instance: full-adder truth table, latency 1
    for (int v = 0; v < 8; v++) begin
      vv = 3'(v);
      bus1.a = vv[2]; bus1.b = vv[1]; bus1.cin = vv[0]; bus1.sub = 1'b0;
      bus1.in_valid = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      lat = 0;
      while (bus1.out_valid !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("w1_%0d_lat", v), 32'(lat), 32'd1);
      check($sformatf("w1_%0d_sum", v), 32'(bus1.sum), 32'(vv[2] ^ vv[1] ^ vv[0]));
      check($sformatf("w1_%0d_cout", v), 32'(bus1.c_out),
            32'((vv[2] & vv[1]) | (vv[2] & vv[0]) | (vv[1] & vv[0])));
      bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
    end

    // in_valid with different operands during RUN must not disturb the captured ones
    start16(16'h0100, 16'h0200, 1'b0, 1'b0);
    bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.sub = 1'b1; bus16.in_valid = 1'b1;
    wait16(lat);
    bus16.in_valid = 1'b0;
    check("run_ign_lat", 32'(lat), 32'd4);
    check("run_ign_sum", 32'(bus16.sum), 32'h0300);
    consume16();

    // Backpressure in DONE with in_valid pulses, then consume with in_valid high
    start16(16'h1234, 16'h0FF0, 1'b0, 1'b0);
    wait16(lat);
    check("bp_lat", 32'(lat), 32'd4);
    for (int c = 0; c < 3; c++) begin
      bus16.a = 16'hAAAA; bus16.b = 16'h5555; bus16.sub = 1'b0;
      bus16.in_valid = (c != 1);
      @(posedge clk); #1;
      check($sformatf("bp%0d_valid", c), 32'(bus16.out_valid), 32'd1);
      check($sformatf("bp%0d_sum", c), 32'(bus16.sum), 32'h2224);
      check($sformatf("bp%0d_flags", c), 32'({bus16.c_out, bus16.ovf}), 32'd0);
      check($sformatf("bp%0d_rdy", c), 32'(bus16.in_ready), 32'd0);
    end
    bus16.a = 16'h0001; bus16.b = 16'h0001; bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    check("pop_valid", 32'(bus16.out_valid), 32'd0);
    check("pop_no_accept", 32'(bus16.in_ready), 32'd1);
    // in_valid still high: accepted on this next edge; out_ready held high through RUN
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    check("acc_next_rdy", 32'(bus16.in_ready), 32'd0);
    wait16(lat);
    check("acc_next_lat", 32'(lat), 32'd4);
    check("acc_next_sum", 32'(bus16.sum), 32'h0002);
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    check("rdy_early_pop", 32'(bus16.out_valid), 32'd0);

    // Leave c_out/ovf set, then reset in the middle of RUN
    start16(16'h8000, 16'h8000, 1'b0, 1'b0);
    wait16(lat);
    consume16();
    start16(16'h1234, 16'h0FF0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus16.out_valid), 32'd0);
    check("mid_rst_rdy",   32'(bus16.in_ready),  32'd1);
    check("mid_rst_sum",   32'(bus16.sum),       32'd0);
    check("mid_rst_cout",  32'(bus16.c_out),     32'd0);
    check("mid_rst_ovf",   32'(bus16.ovf),       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus16.out_valid === 1'b1) seen = 1'b1;
    end
    check("post_rst_no_valid", 32'(seen), 32'd0);
    start16(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    wait16(lat);
    check("post_rst_lat", 32'(lat), 32'd4);
    check("post_rst_sum", 32'(bus16.sum), 32'h1010);
    consume16();

    // Random operands against the arithmetic model, with random result backpressure
    for (int n = 0; n < 150; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      exp18 = model16(ra, rb, rc, rs);
      start16(ra, rb, rc, rs);
      wait16(lat);
      check($sformatf("rnd%0d_lat", n), 32'(lat), 32'd4);
      check($sformatf("rnd%0d_res", n), 32'({bus16.ovf, bus16.c_out, bus16.sum}), 32'(exp18));
      held = bus16.sum;
      d = $urandom_range(0, 2);
      for (int c = 0; c < d; c++) begin
        @(posedge clk); #1;
        check($sformatf("rnd%0d_hold", n), 32'({bus16.out_valid, bus16.sum}), 32'({1'b1, held}));
      end
      consume16();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
